// File: rtl/alu_issue_ctrl.sv
// Decode/issue front end for the registered ALU: decodes RV32I OP/OP-IMM, drives the
// ALU for one EXEC cycle, then presents the registered result on a writeback handshake.
module alu_issue_ctrl #(
  parameter int DataWidth = 8,
  parameter int FuncWidth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [DataWidth-1:0] rs1_data,
  input  logic [DataWidth-1:0] rs2_data,
  output logic [FuncWidth-1:0] alu_func,
  output logic [DataWidth-1:0] alu_op1,
  output logic [DataWidth-1:0] alu_op2,
  input  logic [DataWidth-1:0] alu_result,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [4:0]           wb_rd,
  output logic [DataWidth-1:0] wb_data,
  output logic                 illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_t;

  localparam logic [FuncWidth-1:0] F_ZERO = FuncWidth'(0);
  localparam logic [FuncWidth-1:0] F_ADD  = FuncWidth'(1);
  localparam logic [FuncWidth-1:0] F_SUB  = FuncWidth'(2);
  localparam logic [FuncWidth-1:0] F_SLL  = FuncWidth'(3);
  localparam logic [FuncWidth-1:0] F_SLT  = FuncWidth'(4);
  localparam logic [FuncWidth-1:0] F_XOR  = FuncWidth'(5);
  localparam logic [FuncWidth-1:0] F_OR   = FuncWidth'(6);
  localparam logic [FuncWidth-1:0] F_AND  = FuncWidth'(7);
  localparam logic [FuncWidth-1:0] F_SRL  = FuncWidth'(8);
  localparam logic [FuncWidth-1:0] F_SRA  = FuncWidth'(9);
  localparam logic [FuncWidth-1:0] F_SLTU = FuncWidth'(10);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  state_t state, state_nxt;

  logic [6:0]           opcode, funct7;
  logic [2:0]           funct3;
  logic                 is_op, is_imm, is_shift;
  logic                 dec_legal;
  logic [FuncWidth-1:0] dec_func, func_q;
  logic [DataWidth-1:0] dec_op2, op1_q, op2_q;
  logic [4:0]           rd_q;
  logic                 unused_rs1_idx;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign is_op    = (opcode == OPC_OP);
  assign is_imm   = (opcode == OPC_IMM);
  assign is_shift = is_imm && (funct3 == 3'b001 || funct3 == 3'b101);
  // Register indices arrive pre-read as rs1_data/rs2_data.
  assign unused_rs1_idx = ^instr[19:15];

  always_comb begin
    dec_func = F_ZERO;
    case (funct3)
      3'b000: dec_func = (is_op && funct7 == F7_ALT) ? F_SUB : F_ADD;
      3'b001: dec_func = F_SLL;
      3'b010: dec_func = F_SLT;
      3'b011: dec_func = F_SLTU;
      3'b100: dec_func = F_XOR;
      3'b101: dec_func = (funct7 == F7_ALT) ? F_SRA : F_SRL;
      3'b110: dec_func = F_OR;
      3'b111: dec_func = F_AND;
      default: dec_func = F_ZERO;
    endcase

    dec_legal = 1'b0;
    if (is_op) begin
      dec_legal = (funct7 == F7_BASE) ||
                  (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
    end else if (is_imm) begin
      if (funct3 == 3'b001)      dec_legal = (funct7 == F7_BASE);
      else if (funct3 == 3'b101) dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
      else                       dec_legal = 1'b1;
    end

    dec_op2 = rs2_data;
    if (is_imm) begin
      dec_op2 = is_shift ? DataWidth'(instr[24:20]) : DataWidth'($signed(instr[31:20]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_q <= F_ZERO;
      op1_q  <= '0;
      op2_q  <= '0;
      rd_q   <= '0;
    end else if (state == IDLE && in_valid) begin
      func_q <= dec_func;
      op1_q  <= rs1_data;
      op2_q  <= dec_op2;
      rd_q   <= instr[11:7];
    end
  end

  assign alu_op1 = op1_q;
  assign alu_op2 = op2_q;

  // The function stays applied through WB so the ALU keeps recomputing the same result under stall.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    alu_func  = F_ZERO;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    illegal   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = dec_legal ? EXEC : ERR;
      end
      EXEC: begin
        alu_func  = func_q;
        state_nxt = WB;
      end
      WB: begin
        alu_func = func_q;
        wb_valid = 1'b1;
        wb_rd    = rd_q;
        wb_data  = (rd_q == 5'd0) ? '0 : alu_result;
        if (wb_ready) state_nxt = IDLE;
      end
      ERR: begin
        illegal   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a registered ALU stand-in, an instruction-level reference
// model compared every cycle, and directed vectors with hand-computed results.
module tb_alu_issue_ctrl;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_ready;
  logic [31:0]   instr;
  logic [DW-1:0] rs1_data, rs2_data;
  logic [3:0]    alu_func;
  logic [DW-1:0] alu_op1, alu_op2, alu_result;
  logic          wb_valid, wb_ready;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic          illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DataWidth(DW), .FuncWidth(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_func(alu_func), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] alu_eval(input int fn, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (fn)
      1:  r = a + b;
      2:  r = a - b;
      3:  r = a << b;
      4:  r = {7'b0, ($signed(a) < $signed(b))};
      5:  r = a ^ b;
      6:  r = a | b;
      7:  r = a & b;
      8:  r = a >> b;
      9:  r = $signed(a) >>> b;
      10: r = {7'b0, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Registered ALU: result one cycle after the inputs, held while func is ZERO.
  always @(posedge clk or posedge rst) begin
    if (rst) alu_result <= '0;
    else if (alu_func != 4'd0) alu_result <= alu_eval(int'(alu_func), alu_op1, alu_op2);
  end

  task automatic mdecode(input logic [31:0] ins, input logic [7:0] b,
                         output bit legal, output int fn, output logic [7:0] o2);
    bit op, imm, sh;
    logic [2:0] f3;
    logic [6:0] f7;
    int fmap[8];
    fmap = '{1, 3, 4, 10, 5, 8, 6, 7};
    op  = (ins[6:0] == 7'h33);
    imm = (ins[6:0] == 7'h13);
    f3  = ins[14:12];
    f7  = ins[31:25];
    sh  = imm && (f3 == 3'd1 || f3 == 3'd5);
    if (op)       legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    else if (imm) legal = sh ? ((f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20)) : 1'b1;
    else          legal = 1'b0;
    fn = fmap[f3];
    if (f3 == 3'd0 && op && f7 == 7'h20) fn = 2;
    if (f3 == 3'd5 && f7 == 7'h20)       fn = 9;
    if (op)      o2 = b;
    else if (sh) o2 = {3'b0, ins[24:20]};
    else         o2 = ins[27:20];
  endtask

  bit         m_busy = 1'b0;
  bit         m_legal;
  int         m_age, m_fn;
  logic [7:0] m_a, m_o2, m_data;
  logic [4:0] m_rd;

  // Instruction-level model: one instruction in flight, age counted from acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (!m_legal)                     m_busy = 1'b0;
      else if (m_age >= 1 && wb_ready)  m_busy = 1'b0;
      else                              m_age++;
    end else if (in_valid) begin
      mdecode(instr, rs2_data, m_legal, m_fn, m_o2);
      m_a    = rs1_data;
      m_rd   = instr[11:7];
      m_data = (m_rd == 5'd0) ? 8'h00 : alu_eval(m_fn, m_a, m_o2);
      m_busy = 1'b1;
      m_age  = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (!m_busy) begin
        chk("m_idle_ready", in_ready, 1);
        chk("m_idle_wbv", wb_valid, 0);
        chk("m_idle_ill", illegal, 0);
        chk("m_idle_func", alu_func, 0);
      end else if (!m_legal) begin
        chk("m_err_ready", in_ready, 0);
        chk("m_err_ill", illegal, 1);
        chk("m_err_wbv", wb_valid, 0);
        chk("m_err_func", alu_func, 0);
      end else if (m_age == 0) begin
        chk("m_exec_ready", in_ready, 0);
        chk("m_exec_func", alu_func, m_fn);
        chk("m_exec_op1", alu_op1, m_a);
        chk("m_exec_op2", alu_op2, m_o2);
        chk("m_exec_wbv", wb_valid, 0);
        chk("m_exec_ill", illegal, 0);
      end else begin
        chk("m_wb_ready", in_ready, 0);
        chk("m_wb_wbv", wb_valid, 1);
        chk("m_wb_rd", wb_rd, m_rd);
        chk("m_wb_data", wb_data, m_data);
        chk("m_wb_func", alu_func, m_fn);
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [7:0] a, input logic [7:0] b);
    bit done;
    done = 1'b0;
    @(negedge clk); #2;
    in_valid = 1'b1; instr = ins; rs1_data = a; rs2_data = b;
    for (int i = 0; i < 10 && !done; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk); #2;
      end
    end
    if (!done) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic run(input logic [31:0] ins, input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] efn, input logic [7:0] eop2,
                     input logic [4:0] erd, input logic [7:0] edata);
    wb_ready = 1'b1;
    send(ins, a, b);
    @(negedge clk);
    chk("exec_func", alu_func, efn);
    chk("exec_op1", alu_op1, a);
    chk("exec_op2", alu_op2, eop2);
    chk("exec_in_ready", in_ready, 0);
    chk("exec_wbv", wb_valid, 0);
    @(negedge clk);
    chk("wb_valid", wb_valid, 1);
    chk("wb_rd", wb_rd, erd);
    chk("wb_data", wb_data, edata);
    chk("wb_in_ready", in_ready, 0);
    @(negedge clk);
    chk("post_in_ready", in_ready, 1);
    chk("post_wbv", wb_valid, 0);
  endtask

  task automatic bad(input logic [31:0] ins);
    wb_ready = 1'b1;
    send(ins, 8'h11, 8'h22);
    @(negedge clk);
    chk("ill_pulse", illegal, 1);
    chk("ill_wbv", wb_valid, 0);
    chk("ill_in_ready", in_ready, 0);
    @(negedge clk);
    chk("ill_end", illegal, 0);
    chk("ill_wbv2", wb_valid, 0);
    chk("ill_ready_back", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0; wb_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_func", alu_func, 0);
    chk("rst_op1", alu_op1, 0);
    chk("rst_op2", alu_op2, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_ill", illegal, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    run(32'h002081B3, 8'h7F, 8'h01, 4'd1,  8'h01, 5'd3, 8'h80); // add x3
    run(32'h402082B3, 8'h00, 8'h01, 4'd2,  8'h01, 5'd5, 8'hFF); // sub x5
    run(32'hFFF08313, 8'h10, 8'h00, 4'd1,  8'hFF, 5'd6, 8'h0F); // addi x6,-1
    run(32'h4020D213, 8'h80, 8'h00, 4'd9,  8'h02, 5'd4, 8'hE0); // srai x4,2
    run(32'h00909393, 8'h81, 8'h00, 4'd3,  8'h09, 5'd7, 8'h00); // slli x7,9
    run(32'h0020B433, 8'h01, 8'hFF, 4'd10, 8'hFF, 5'd8, 8'h01); // sltu x8
    bad(32'h022081B3); // mul
    bad(32'h0000A183); // load
    bad(32'h40909393); // slli with funct7=0100000

    // Writeback stall with a new instruction waiting on in_valid.
    wb_ready = 1'b0;
    send(32'h002081B3, 8'h05, 8'h06);
    in_valid = 1'b1; instr = 32'h402082B3; rs1_data = 8'h09; rs2_data = 8'h04;
    @(negedge clk);
    chk("stall_exec_func", alu_func, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_wbv", wb_valid, 1);
      chk("stall_data", wb_data, 8'h0B);
      chk("stall_rd", wb_rd, 3);
      chk("stall_in_ready", in_ready, 0);
    end
    #2 wb_ready = 1'b1;
    @(negedge clk);
    chk("hs_idle_ready", in_ready, 1);
    chk("hs_idle_func", alu_func, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("next_func", alu_func, 2);
    chk("next_op1", alu_op1, 8'h09);
    @(negedge clk);
    chk("next_data", wb_data, 8'h05);
    chk("next_rd", wb_rd, 5);
    @(negedge clk);

    // Asynchronous reset while in writeback.
    wb_ready = 1'b0;
    send(32'h002081B3, 8'h7F, 8'h01);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_wbv", wb_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_wbv", wb_valid, 0);
    chk("arst_func", alu_func, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_data", wb_data, 0);
    @(negedge clk); #2;
    rst = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_wbv", wb_valid, 0);

    run(32'h00208033, 8'h12, 8'h34, 4'd1, 8'h34, 5'd0, 8'h00); // add x0
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
